dsi_lanes_scheduler: RTL



---
 rtl/dsi_sched_pkg.sv | 14 +
 rtl/dsi_lanes_scheduler_if.sv | 10 +
 rtl/dsi_sched_timer.sv | 18 +
 rtl/dsi_lanes_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dsi_sched_pkg.sv
// dsi_sched_pkg: shared state encoding, lane limits and lane-mask helper for the DSI lane scheduler.
package dsi_sched_pkg;
    localparam int MAX_LANES = 4;
    localparam int LP_LANE   = 0;

    typedef enum logic [3:0] {
        IDLE, CLK_START, CLK_WAIT, DATA_START, DATA_STREAM, DATA_DRAIN,
        CLK_HOLD, CLK_STOP, LP_START, LP_STREAM, LP_WAIT
    } sched_state_t;

    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] n);
        for (int i = 0; i < MAX_LANES; i++) lane_mask[i] = i <= int'(n);
    endfunction
endpackage

// File: rtl/dsi_lanes_scheduler_if.sv
// dsi_lanes_scheduler_if: word stream from the packet assembler into the lane scheduler.
interface dsi_lanes_scheduler_if #(parameter int NUM_LANES = 4) ();
    logic                   valid;
    logic [8*NUM_LANES-1:0] data;
    logic                   last;
    logic                   lp;
    logic                   ready;
    modport master (output valid, data, last, lp, input ready);
    modport slave  (input valid, data, last, lp, output ready);
endinterface

// File: rtl/dsi_sched_timer.sv
// dsi_sched_timer: loadable 8-bit down-counter; done marks the final tick of a count.
module dsi_sched_timer (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] val,
    output logic       done
);
    logic [7:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= val;
        else if (en && cnt != 8'd0) cnt <= cnt - 8'd1;

    assign done = cnt <= 8'd1;
endmodule

// File: rtl/dsi_lanes_scheduler.sv
// dsi_lanes_scheduler: orders clock/data lane start-stop and stripes assembler words across data lanes.
module dsi_lanes_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int T_CLK_PRE        = 8,
    parameter int T_CLK_POST       = 8,
    parameter int CLK_IDLE_TIMEOUT = 64
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   lanes_enable,
    input  logic [1:0]             active_lanes,
    dsi_lanes_scheduler_if.slave   iface,
    output logic [NUM_LANES-1:0]   lane_start_rqst,
    output logic [NUM_LANES-1:0]   lane_fin_rqst,
    output logic                   lane_mode_lp,
    output logic [8*NUM_LANES-1:0] lane_data,
    input  logic [NUM_LANES-1:0]   lane_data_rqst,
    input  logic [NUM_LANES-1:0]   lane_active,
    output logic                   clk_start_rqst,
    output logic                   clk_fin_rqst,
    input  logic                   clk_active,
    output logic                   busy,
    output logic                   underrun_err
);
    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES || T_CLK_PRE > 255 || T_CLK_POST > 255 || CLK_IDLE_TIMEOUT > 255) begin : g_param_check
        $error("dsi_lanes_scheduler: parameter out of range");
    end

    sched_state_t           state, nxt;
    logic [NUM_LANES-1:0]   mask;
    logic [MAX_LANES-1:0]   mask_all;
    logic [8*NUM_LANES-1:0] byte_en;
    logic                   drop, hs, start_ok, lanes_busy;
    logic                   tmr_load, tmr_en, tmr_done;
    logic [7:0]             tmr_val;
    logic                   unused_ok;

    assign mask_all   = lane_mask(active_lanes);
    assign hs         = lane_data_rqst[LP_LANE];
    assign start_ok   = lanes_enable & iface.valid & ~drop;
    assign lanes_busy = |(lane_active & mask);
    assign busy       = state != IDLE && state != CLK_HOLD;
    assign unused_ok  = ^{lane_data_rqst, mask_all};

    always_comb
        for (int k = 0; k < NUM_LANES; k++) byte_en[8*k +: 8] = {8{mask[k]}};

    // drop swallows the tail of a packet cut short by an underrun
    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
            drop  <= 1'b0;
        end else begin
            state <= nxt;
            if ((state == IDLE || state == CLK_HOLD) && nxt != state) mask <= mask_all[NUM_LANES-1:0];
            drop <= underrun_err | (drop & ~(iface.valid & iface.last));
        end

    always_comb begin
        nxt             = state;
        iface.ready     = drop;
        lane_start_rqst = '0;
        lane_fin_rqst   = '0;
        lane_data       = '0;
        lane_mode_lp    = 1'b0;
        clk_start_rqst  = 1'b0;
        clk_fin_rqst    = 1'b0;
        underrun_err    = 1'b0;
        case (state)
            IDLE:       nxt = start_ok ? (iface.lp ? LP_START : CLK_START) : IDLE;
            CLK_START: begin
                clk_start_rqst = 1'b1;
                nxt            = CLK_WAIT;
            end
            CLK_WAIT:   nxt = (clk_active & tmr_done) ? DATA_START : CLK_WAIT;
            DATA_START: begin
                lane_start_rqst = mask;
                nxt             = DATA_STREAM;
            end
            DATA_STREAM: if (hs) begin
                iface.ready   = iface.valid;
                lane_data     = iface.valid ? iface.data & byte_en : '0;
                lane_fin_rqst = (iface.valid & ~iface.last) ? '0 : mask;
                underrun_err  = ~iface.valid;
                nxt           = (iface.valid & ~iface.last) ? DATA_STREAM : DATA_DRAIN;
            end
            DATA_DRAIN: nxt = (~lanes_busy & tmr_done) ? CLK_HOLD : DATA_DRAIN;
            // a new HS packet outranks the idle timeout
            CLK_HOLD:   nxt = (start_ok & ~iface.lp) ? DATA_START :
                              (start_ok | tmr_done | ~lanes_enable) ? CLK_STOP : CLK_HOLD;
            CLK_STOP: begin
                clk_fin_rqst = 1'b1;
                nxt          = clk_active ? CLK_STOP : IDLE;
            end
            LP_START: begin
                lane_start_rqst[LP_LANE] = 1'b1;
                lane_mode_lp             = 1'b1;
                nxt                      = LP_STREAM;
            end
            LP_STREAM: begin
                lane_mode_lp = 1'b1;
                if (hs) begin
                    iface.ready                 = iface.valid;
                    lane_data[8*LP_LANE +: 8]   = iface.valid ? iface.data[7:0] : 8'h00;
                    lane_fin_rqst[LP_LANE]      = ~iface.valid | iface.last;
                    underrun_err                = ~iface.valid;
                    nxt                         = (iface.valid & ~iface.last) ? LP_STREAM : LP_WAIT;
                end
            end
            LP_WAIT: begin
                lane_mode_lp = 1'b1;
                nxt          = lane_active[LP_LANE] ? LP_WAIT : IDLE;
            end
            default:    nxt = IDLE;
        endcase
    end

    // one timer serves all waits: reloaded on every state change and while drained lanes are still busy
    assign tmr_val  = nxt == CLK_WAIT ? 8'(T_CLK_PRE) : nxt == DATA_DRAIN ? 8'(T_CLK_POST) : 8'(CLK_IDLE_TIMEOUT);
    assign tmr_load = nxt != state || (state == DATA_DRAIN && lanes_busy);
    assign tmr_en   = (state == CLK_WAIT && clk_active) || state == DATA_DRAIN || state == CLK_HOLD;

    dsi_sched_timer u_timer (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .val     (tmr_val),
        .done    (tmr_done)
    );
endmodule
